// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - shared types and frame-length classification for the frame-length queue
package spi_frame_pkg;

    localparam int CNT_W      = 16;
    localparam int WORD_BITS  = 8;
    localparam int WORD_SHIFT = $clog2(WORD_BITS);
    localparam int MAX_BITS   = 64;

    typedef struct packed {
        logic [CNT_W-1:0]            len;
        logic [CNT_W-WORD_SHIFT-1:0] words;
        logic                        partial;
        logic                        oversize;
    } frame_entry_t;

    function automatic frame_entry_t classify_len(input logic [CNT_W-1:0] len,
                                                  input int max_bits = MAX_BITS);
        frame_entry_t e;
        e.len      = len;
        e.words    = len[CNT_W-1:WORD_SHIFT];
        e.partial  = |len[WORD_SHIFT-1:0];
        e.oversize = (int'(len) > max_bits);
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_en;
    logic             push_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_frame_len_queue.sv
// rtl/spi_frame_len_queue.sv - classifies SPI frame lengths, queues them and keeps frame statistics
module spi_frame_len_queue
    import spi_frame_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CNT_W     = spi_frame_pkg::CNT_W,
    parameter int WORD_BITS = spi_frame_pkg::WORD_BITS,
    parameter int MAX_BITS  = spi_frame_pkg::MAX_BITS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CNT_W-1:0]                    len_in,
    input  logic                                len_in_rdy,
    output logic [CNT_W-1:0]                    out_len,
    output logic [CNT_W-$clog2(WORD_BITS)-1:0]  out_words,
    output logic                                out_partial,
    output logic                                out_oversize,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(DEPTH):0]              level,
    input  logic                                clear_stats,
    output logic [15:0]                         frames_total,
    output logic [15:0]                         frames_empty,
    output logic [15:0]                         frames_dropped,
    output logic                                overflow
);

    frame_entry_t new_entry;
    frame_entry_t head;
    frame_entry_t held;
    frame_entry_t shown;
    logic         full;
    logic         empty;
    logic         push_req;
    logic         zero_evt;
    logic         pop_fire;
    logic         accept;
    logic         drop;

    assign push_req  = len_in_rdy && (len_in != '0);
    assign zero_evt  = len_in_rdy && (len_in == '0);
    assign pop_fire  = out_ready && !empty;
    assign accept    = push_req && (!full || pop_fire);
    assign drop      = push_req && full && !pop_fire;
    assign new_entry = classify_len(len_in, MAX_BITS);

    sync_fifo_fwft #(
        .WIDTH ($bits(frame_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (new_entry),
        .full      (full),
        .pop       (out_ready),
        .empty     (empty),
        .head      (head),
        .level     (level)
    );

    // Shadow of the last presented head so the outputs hold once the queue empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      held <= '0;
        else if (!empty) held <= head;
    end

    assign shown        = empty ? held : head;
    assign out_valid    = !empty;
    assign out_len      = shown.len;
    assign out_words    = shown.words;
    assign out_partial  = shown.partial;
    assign out_oversize = shown.oversize;

    function automatic logic [15:0] bump(input logic [15:0] v, input logic inc);
        return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Clear applies first so an event in the clearing cycle still counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_total   <= '0;
            frames_empty   <= '0;
            frames_dropped <= '0;
            overflow       <= 1'b0;
        end else begin
            frames_total   <= bump(clear_stats ? 16'd0 : frames_total, accept);
            frames_empty   <= bump(clear_stats ? 16'd0 : frames_empty, zero_evt);
            frames_dropped <= bump(clear_stats ? 16'd0 : frames_dropped, drop);
            overflow       <= (overflow && !clear_stats) || drop;
        end
    end

endmodule

// File: tb/tb_spi_frame_len_queue.sv
// tb/tb_spi_frame_len_queue.sv - randomized self-checking bench for spi_frame_len_queue
module tb_spi_frame_len_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CNT_W-1:0]  len_in;
    logic              len_in_rdy;
    logic [CNT_W-1:0]  out_len;
    logic [CNT_W-4:0]  out_words;
    logic              out_partial;
    logic              out_oversize;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        level;
    logic              clear_stats;
    logic [15:0]       frames_total;
    logic [15:0]       frames_empty;
    logic [15:0]       frames_dropped;
    logic              overflow;

    spi_frame_len_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .len_in         (len_in),
        .len_in_rdy     (len_in_rdy),
        .out_len        (out_len),
        .out_words      (out_words),
        .out_partial    (out_partial),
        .out_oversize   (out_oversize),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .clear_stats    (clear_stats),
        .frames_total   (frames_total),
        .frames_empty   (frames_empty),
        .frames_dropped (frames_dropped),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int m_total = 0;
    int m_empty = 0;
    int m_drop  = 0;
    bit m_ovf   = 0;

    // Applies one cycle of inputs, lets the edge pass, then advances the model.
    task automatic drive(input bit rdy, input int len, input bit rdy_out, input bit clr);
        bit pop;
        len_in_rdy  = rdy;
        len_in      = CNT_W'(len);
        out_ready   = rdy_out;
        clear_stats = clr;
        pop = rdy_out && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (clr) begin
            m_total = 0; m_empty = 0; m_drop = 0; m_ovf = 0;
        end
        if (pop) void'(mq.pop_front());
        if (rdy && len == 0) begin
            if (m_empty < 65535) m_empty++;
        end else if (rdy) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(len);
                if (m_total < 65535) m_total++;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
        len_in_rdy = 0; out_ready = 0; clear_stats = 0; len_in = '0;
    endtask

    task automatic drain();
        while (mq.size() > 0) drive(0, 0, 1, 0);
    endtask

    task automatic test_reset();
        rst_n = 0; len_in = '0; len_in_rdy = 0; out_ready = 0; clear_stats = 0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if ({out_len, out_words, out_partial, out_oversize} !== '0) begin errors++; $display("FAIL reset_out got %0d/%0d/%0b/%0b want 0", out_len, out_words, out_partial, out_oversize); end
        checks++; if ({frames_total, frames_empty, frames_dropped, overflow} !== '0) begin errors++; $display("FAIL reset_stats got %0d/%0d/%0d/%0b want 0", frames_total, frames_empty, frames_dropped, overflow); end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_single_frame();
        drive(1, 16, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_len !== 16'd16 || out_words !== 13'd2 || out_partial !== 1'b0 || out_oversize !== 1'b0) begin errors++; $display("FAIL single_fields got %0d/%0d/%0b/%0b want 16/2/0/0", out_len, out_words, out_partial, out_oversize); end
        checks++; if (level !== 4'd1 || frames_total !== 16'd1) begin errors++; $display("FAIL single_level_total got %0d/%0d want 1/1", level, frames_total); end
        drain();
        checks++; if (out_valid !== 1'b0 || out_len !== 16'd16) begin errors++; $display("FAIL single_hold got valid=%0b len=%0d want 0/16", out_valid, out_len); end
    endtask

    task automatic test_classification();
        drive(1, 13, 0, 0);
        drive(1, 72, 0, 0);
        checks++; if (out_len !== 16'd13 || out_words !== 13'd1 || out_partial !== 1'b1 || out_oversize !== 1'b0) begin errors++; $display("FAIL class_first got %0d/%0d/%0b/%0b want 13/1/1/0", out_len, out_words, out_partial, out_oversize); end
        drive(0, 0, 1, 0);
        checks++; if (out_len !== 16'd72 || out_words !== 13'd9 || out_partial !== 1'b0 || out_oversize !== 1'b1) begin errors++; $display("FAIL class_second got %0d/%0d/%0b/%0b want 72/9/0/1", out_len, out_words, out_partial, out_oversize); end
        drain();
    endtask

    task automatic test_zero_length();
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %0b want 0", out_valid); end
        checks++; if (frames_empty !== 16'd1 || frames_total !== 16'd0) begin errors++; $display("FAIL zero_counts got empty=%0d total=%0d want 1/0", frames_empty, frames_total); end
    endtask

    task automatic test_overflow();
        int exp;
        for (int i = 1; i <= 9; i++) drive(1, i, 0, 0);
        checks++; if (level !== 4'd8 || frames_dropped !== 16'd1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_state got level=%0d drop=%0d ovf=%0b want 8/1/1", level, frames_dropped, overflow); end
        exp = 1;
        while (out_valid === 1'b1 && exp <= 9) begin
            checks++; if (out_len !== CNT_W'(exp)) begin errors++; $display("FAIL ovf_order got %0d want %0d", out_len, exp); end
            drive(0, 0, 1, 0);
            exp++;
        end
        checks++; if (exp !== 9) begin errors++; $display("FAIL ovf_drain_count got %0d want 8", exp - 1); end
        mq.delete();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) drive(1, 20 + i, 0, 0);
        drive(1, 40, 1, 0);
        checks++; if (level !== 4'd8 || frames_dropped !== 16'(m_drop)) begin errors++; $display("FAIL fullpp_state got level=%0d drop=%0d want 8/%0d", level, frames_dropped, m_drop); end
        drive(0, 0, 0, 1);
        checks++; if ({frames_total, frames_empty, frames_dropped, overflow} !== '0) begin errors++; $display("FAIL clear_stats got %0d/%0d/%0d/%0b want 0", frames_total, frames_empty, frames_dropped, overflow); end
        checks++; if (level !== 4'd8 || out_len !== 16'd21) begin errors++; $display("FAIL clear_queue got level=%0d head=%0d want 8/21", level, out_len); end
        drive(1, 0, 0, 1);
        checks++; if (frames_empty !== 16'd1) begin errors++; $display("FAIL clear_event got %0d want 1", frames_empty); end
        for (int i = 0; i < DEPTH - 1; i++) drive(0, 0, 1, 0);
        checks++; if (out_len !== 16'd40 || level !== 4'd1) begin errors++; $display("FAIL fullpp_last got %0d level=%0d want 40/1", out_len, level); end
        drain();
    endtask

    task automatic test_random();
        int len;
        int r;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = 0;
            else if (r == 1) len = $urandom_range(65, 65535);
            else             len = $urandom_range(1, 80);
            drive($urandom_range(0, 1), len, $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
            checks++; if (out_valid !== (mq.size() > 0) || level !== 4'(mq.size())) begin errors++; $display("FAIL rand_occupancy got valid=%0b level=%0d want level=%0d", out_valid, level, mq.size()); end
            checks++; if (frames_total !== 16'(m_total) || frames_empty !== 16'(m_empty) || frames_dropped !== 16'(m_drop) || overflow !== m_ovf) begin errors++; $display("FAIL rand_stats got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", frames_total, frames_empty, frames_dropped, overflow, m_total, m_empty, m_drop, m_ovf); end
            if (mq.size() > 0) begin
                checks++;
                if (out_len !== 16'(mq[0]) || out_words !== 13'(mq[0] / 8) || out_partial !== ((mq[0] % 8) != 0) || out_oversize !== (mq[0] > 64)) begin
                    errors++; $display("FAIL rand_head got %0d/%0d/%0b/%0b for len %0d", out_len, out_words, out_partial, out_oversize, mq[0]);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, 5, 0, 0);
        drive(1, 6, 0, 0);
        drive(1, 7, 0, 0);
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL midrst_queue got valid=%0b level=%0d want 0/0", out_valid, level); end
        checks++; if ({frames_total, frames_empty, frames_dropped, overflow} !== '0) begin errors++; $display("FAIL midrst_stats got %0d/%0d/%0d/%0b want 0", frames_total, frames_empty, frames_dropped, overflow); end
        @(posedge clk); #1;
        rst_n = 1;
        mq.delete(); m_total = 0; m_empty = 0; m_drop = 0; m_ovf = 0;
        drive(1, 8, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_len !== 16'd8 || out_words !== 13'd1 || level !== 4'd1 || frames_total !== 16'd1) begin errors++; $display("FAIL midrst_push got valid=%0b len=%0d words=%0d level=%0d total=%0d want 1/8/1/1/1", out_valid, out_len, out_words, level, frames_total); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_classification();
        test_zero_length();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_len_queue.md
Name: spi_frame_len_queue

Overview:
- Downstream consumer of the SPI front-end's frame-length output (`cycles_num` / `cycles_num_rdy` pulse, one per CS deassertion).
- Classifies each frame length: byte count, partial-byte flag, oversize flag.
- Buffers the classified frames in a first-word-fall-through queue behind a valid/ready port for the control logic.
- Keeps saturating statistics counters and a sticky overflow flag.

Parameters:
- DEPTH, 8, queue entries; power of two, at least 2.
- CNT_W, 16, frame-length width; equals the front-end count width.
- WORD_BITS, 8, bits per word; power of two.
- MAX_BITS, 64, largest legal frame length in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- len_in  in  CNT_W  frame length in SCLK rising edges; sampled only when len_in_rdy=1.
- len_in_rdy  in  1  single-cycle strobe; one per finished frame.
- out_len  out  CNT_W  head-entry length.
- out_words  out  CNT_W-log2(WORD_BITS)  head length / WORD_BITS, truncated.
- out_partial  out  1  head length mod WORD_BITS != 0.
- out_oversize  out  1  head length > MAX_BITS.
- out_valid  out  1  queue not empty.
- out_ready  in  1  consumer accepts the head.
- level  out  log2(DEPTH)+1  current occupancy.
- clear_stats  in  1  single-cycle clear of the counters and the sticky flag.
- frames_total  out  16  accepted frames; saturating.
- frames_empty  out  16  zero-length frames discarded; saturating.
- frames_dropped  out  16  frames lost because the queue was full; saturating.
- overflow  out  1  sticky; set on any drop.

Behaviour:
- Reset (async assert, synchronous release on clk):
  - pointers and level = 0; out_valid = 0;
  - out_len, out_words, out_partial, out_oversize = 0;
  - all counters = 0; overflow = 0.
- Push condition: len_in_rdy=1 and len_in != 0.
  - Entry = {len_in, len_in>>log2(WORD_BITS), |len_in[log2(WORD_BITS)-1:0], len_in>MAX_BITS}.
  - Classification is computed at push time and stored; no arithmetic on the read path.
- Zero length (len_in_rdy=1, len_in=0): no push; frames_empty +1.
- Pop: out_valid and out_ready both 1 at a rising edge.
- Latency: push into an empty queue at edge N makes out_valid=1 and the out_* fields valid immediately after edge N (FWFT). No combinational path from len_in to out_*.
- out_* are driven from the head entry whenever out_valid=1.
  - When out_valid=0 they hold their last value; the consumer must ignore them.
- Full, no pop in the same cycle:
  - push is dropped and queue contents are unchanged;
  - frames_dropped +1; overflow <= 1.
- Full, pop in the same cycle: the push is accepted; level stays DEPTH.
- Empty, push in the same cycle as out_ready=1: no pop (out_valid was 0); level becomes 1.
- Simultaneous push and pop otherwise: level unchanged; both pointers advance.
- Pointers: log2(DEPTH)+1 bits with wrap bit.
  - full = same index, wrap bits differ.
  - empty = pointers equal.
- frames_total +1 on each accepted push.
- All three counters saturate at 16'hFFFF; they never wrap.
- clear_stats=1 zeroes the counters and overflow at that edge.
  - An event in the same cycle is applied after the clear: the affected counter = 1 and/or overflow = 1.
  - Queue contents are unaffected.
- len_in_rdy held high for several cycles is treated as one frame per cycle (no edge detection).
  - This is legal, because the front-end guarantees single-cycle pulses.
- Mid-operation reset: the queue is discarded instantly; out_valid falls asynchronously with rst_n.

Decomposition:
- Package spi_frame_pkg holds:
  - localparams CNT_W and WORD_BITS;
  - typedef frame_entry_t (len, words, partial, oversize);
  - function classify_len(len) returning frame_entry_t.
- Sub-module sync_fifo_fwft holds the storage and pointers (parameters WIDTH, DEPTH; push/full/pop/empty/level).
- Classification, counters and drop logic live in the top module.

Test Plan:
- Single frame: len_in=16 strobe, out_ready=0 -> next cycle out_valid=1, out_len=16, out_words=2, out_partial=0, out_oversize=0, level=1, frames_total=1.
- Classification: push 13, then 72; pop both -> first entry words=1, partial=1, oversize=0; second entry words=9, partial=0, oversize=1.
- Zero length: strobe with len_in=0 -> out_valid stays 0; frames_empty=1, frames_total=0.
- Overflow: 9 strobes (lengths 1..9), out_ready=0 -> level=8, frames_dropped=1, overflow=1; draining yields 1..8 in order.
- Full with simultaneous push and pop: queue full, strobe 40 with out_ready=1 -> level stays 8, frames_dropped unchanged, 40 emerges last; then assert clear_stats -> counters=0, overflow=0, queue intact.
- Reset mid-stream: 3 entries queued, pulse rst_n low -> out_valid=0, level=0, all counters=0 immediately; a subsequent push of 8 works normally.
